// File: rtl/complex_tree_adder_acc.sv
// complex_tree_adder_acc
//   Fully pipelined complex adder tree with an optional accumulate step.
//   A start strobe captures NI complex operands; LG = log2(NI) pairwise adder
//   levels reduce them at full precision. An output stage then optionally adds
//   the previous result and narrows each component back to W bits, either
//   wrapping or saturating. Latency is LG+1 cycles from the start edge.
//
// Parameters
//   NI  : number of complex operands (power of two, 2..64)
//   W   : width of each real/imag component (signed)
//   SAT : 0 = wrap on narrowing, 1 = saturate on narrowing
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : asynchronous active-high reset
//   start       : one-cycle strobe, inputs/accum valid this cycle
//   accum       : sampled with start; 1 = add to the previous summation
//   inputs      : operand i at [i*2W +: 2W], real in upper W bits, imag in lower
//   summation   : registered result, same real/imag packing
//   finish      : one-cycle pulse, summation valid this cycle
//   finish_dash : finish delayed by one cycle
//   overflow    : qualified by finish; a component did not fit in W bits
//   busy        : a start is in flight and has not yet produced finish
module complex_tree_adder_acc #(
  parameter int NI  = 8,
  parameter int W   = 32,
  parameter int SAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              accum,
  input  logic [NI*2*W-1:0] inputs,
  output logic [2*W-1:0]    summation,
  output logic              finish,
  output logic              finish_dash,
  output logic              overflow,
  output logic              busy
);

  localparam int LG    = $clog2(NI);
  localparam int WT    = W + LG;       // tree node width (widest level)
  localparam int WO    = W + LG + 1;   // width after the accumulate add
  localparam int NODES = 2 * NI - 1;
  localparam int TOP   = NODES - 1;

  // All tree levels live in one flat array: level k starts at
  // 2*NI - (2*NI >> k) and holds NI >> k nodes; the final sum is the last node.
  logic signed [WT-1:0] node_re_q [NODES];
  logic signed [WT-1:0] node_im_q [NODES];

  logic [LG:0]    vld_q, vld_d;
  logic [LG:0]    tag_q, tag_d;
  logic [2*W-1:0] summation_q, summation_d;
  logic           overflow_q, overflow_d;
  logic           finish_q, finish_dash_q;

  // Datapath registers carry no reset; only valids and tags qualify them.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int unsigned i = 0; i < NI; i++) begin
        node_re_q[i] <= {{LG{inputs[i*2*W+2*W-1]}}, inputs[i*2*W+W +: W]};
        node_im_q[i] <= {{LG{inputs[i*2*W+W-1]}},   inputs[i*2*W   +: W]};
      end
    end
    for (int unsigned k = 1; k <= LG; k++) begin
      for (int unsigned i = 0; i < (NI >> k); i++) begin
        node_re_q[2*NI - ((2*NI) >> k) + i] <=
          node_re_q[2*NI - ((2*NI) >> (k-1)) + 2*i] +
          node_re_q[2*NI - ((2*NI) >> (k-1)) + 2*i + 1];
        node_im_q[2*NI - ((2*NI) >> k) + i] <=
          node_im_q[2*NI - ((2*NI) >> (k-1)) + 2*i] +
          node_im_q[2*NI - ((2*NI) >> (k-1)) + 2*i + 1];
      end
    end
  end

  // Value fits in W signed bits when all bits from W-1 upward agree.
  function automatic logic fits(input logic [WO-1:0] v);
    return (&v[WO-1:W-1]) | ~(|v[WO-1:W-1]);
  endfunction

  function automatic logic [W-1:0] narrow(input logic [WO-1:0] v);
    if (SAT != 0 && !fits(v))
      return v[WO-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return v[W-1:0];
  endfunction

  logic [WO-1:0] full_re, full_im;

  always_comb begin
    vld_d = {vld_q[LG-1:0], start};
    tag_d = {tag_q[LG-1:0], start & accum};

    full_re = {node_re_q[TOP][WT-1], node_re_q[TOP]};
    full_im = {node_im_q[TOP][WT-1], node_im_q[TOP]};
    // Accumulate reads the registered summation, so back-to-back finishes
    // chain onto the result produced on the immediately preceding edge.
    if (tag_q[LG]) begin
      full_re = full_re + {{(LG+1){summation_q[2*W-1]}}, summation_q[2*W-1:W]};
      full_im = full_im + {{(LG+1){summation_q[W-1]}},   summation_q[W-1:0]};
    end

    summation_d = {narrow(full_re), narrow(full_im)};
    overflow_d  = ~fits(full_re) | ~fits(full_im);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q         <= '0;
      tag_q         <= '0;
      summation_q   <= '0;
      overflow_q    <= 1'b0;
      finish_q      <= 1'b0;
      finish_dash_q <= 1'b0;
    end else begin
      vld_q         <= vld_d;
      tag_q         <= tag_d;
      finish_q      <= vld_q[LG];
      finish_dash_q <= finish_q;
      if (vld_q[LG]) begin
        summation_q <= summation_d;
        overflow_q  <= overflow_d;
      end
    end
  end

  assign summation   = summation_q;
  assign overflow    = overflow_q;
  assign finish      = finish_q;
  assign finish_dash = finish_dash_q;
  assign busy        = |vld_q;

endmodule

// File: doc/complex_tree_adder_acc.md
COMPLEX_TREE_ADDER_ACC -- requirements
Module: complex_tree_adder_acc

Interface
REQ-001 Parameter NI, default 8, meaning: number of complex operands; SHALL be a power of two, 2..64.
REQ-002 Parameter W, default 32, meaning: width of each real/imag component, signed two's complement.
REQ-003 Parameter SAT, default 0, meaning: 0 = wrap on narrowing, 1 = saturate on narrowing.
REQ-004 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle strobe; inputs and accum are valid this cycle.
REQ-007 accum  input  1  sampled with start; 1 = add this result to the previous summation.
REQ-008 inputs  input  NI*2W  operand i at [i*2W+2W-1 : i*2W]; real half [2W-1:W], imag half [W-1:0].
REQ-009 summation  output  2W  registered result, same real/imag packing.
REQ-010 finish  output  1  one-cycle pulse; summation is valid this cycle.
REQ-011 finish_dash  output  1  finish delayed by exactly one cycle.
REQ-012 overflow  output  1  qualified by finish; set when either component was wrapped or saturated.
REQ-013 busy  output  1  high while any accepted start has not yet produced finish.

Function
REQ-014 Define LG = log2(NI) and latency L = LG+1.
REQ-015 Stage 0: on posedge with start=1, register all operands, accum tag, and valid=1; otherwise valid=0 and operands hold.
REQ-016 Stages 1..LG: each stage adds adjacent pairs of the previous stage; real and imag sum independently; valid and accum tag shift one stage per cycle.
REQ-017 Tree arithmetic SHALL be sign-extended and full precision: level k width = W+k; no intermediate overflow.
REQ-018 Output stage, when the stage-LG valid is 1: sum = tree result if tag=0, else sign-extended summation + tree result (width W+LG+1); narrow each component to W bits.
REQ-019 Narrowing with SAT=0: keep low W bits; with SAT=1: clamp to [-2^(W-1), 2^(W-1)-1].
REQ-020 overflow = 1 if either component's full-precision value lies outside the W-bit range, regardless of SAT.
REQ-021 summation, overflow, and finish update together; finish is high for exactly one cycle per accepted start, L cycles after the start edge.
REQ-022 summation and overflow SHALL hold between finishes.
REQ-023 The pipeline is fully pipelined: a start is accepted on every cycle, including back-to-back cycles; there is no backpressure; results emerge in start order.
REQ-024 For consecutive finishes, accum=1 SHALL use the summation produced by the immediately preceding finish (same-edge chaining).
REQ-025 busy = OR of all stage valids and the output-pending valid; busy is combinational from registers only.
REQ-026 accum=1 on the first start after reset accumulates onto 0.

Reset
REQ-027 While rst=1, all valids, accum tags, summation, overflow, finish, and finish_dash SHALL be 0 immediately, independent of clk.
REQ-028 Reset mid-operation SHALL discard every in-flight start: no finish for them after release.
REQ-029 A start sampled on the first posedge after rst deasserts SHALL be accepted normally.

Verification
REQ-030 NI=8, W=32; all operands re=1, im=-2; one start, accum=0 -> 4 cycles later summation re=8, im=-16 (0xFFFFFFF0); finish for 1 cycle; finish_dash the next cycle; overflow=0.
REQ-031 Three back-to-back starts, all operands re=1/2/3, im=0 -> three consecutive finish cycles with re=8, 16, 24; busy stays high until the last finish.
REQ-032 Start with operands re=1 and accum=0, then the next cycle start with operands re=1 and accum=1 -> summation re=8, then re=16.
REQ-033 All operands re=0x7FFFFFFF, im=0: SAT=0 -> re=0xFFFFFFF8, overflow=1; SAT=1 -> re=0x7FFFFFFF, overflow=1; im=0.
REQ-034 Start, then assert rst 2 cycles later for 1 cycle -> no finish, summation=0, busy=0; a subsequent start completes in 4 cycles.
REQ-035 NI=2 instance: start with re=5 and re=-7 -> finish 2 cycles later with re=-2 (0xFFFFFFFE).
